hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage ARM pipeline. Drives stall/flush enables of the
//  F, D, E, M and W pipeline registers and the E-stage operand forwarding selects. Resolves

---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing control for the 5-stage ARM pipeline.
//   Forwarding : ForwardAE/ForwardBE pick the E-stage operands
//                (00 register file, 01 W result, 10 M ALU result).
//   Stalls     : StallF/D/E/M hold the pipeline registers.
//   Flushes    : FlushD/E/W load a bubble into the pipeline registers.
//   Hazards    : load-use, pending PC writes, taken branches, and data
//                memory waits on MemReqM/MemReadyM.
//   Memory FSM : RUN -> MEM_WAIT -> TRAP, with a MAX_WAIT-cycle timeout.
//                TRAP sets the sticky MemTimeout flag.
//   Counters   : StallCount counts StallF cycles, FlushCount counts FlushE
//                cycles. Both saturate and are cleared by CntClr.
// Reset is asynchronous and active-high (reset).
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             CntClr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_t;

  localparam int          WW        = $clog2(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  state_t        state, nstate;
  logic [WW-1:0] wait_cnt;
  logic          ldStall, pcPend, memStall;

  assign ldStall = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pcPend  = PCSrcD | PCSrcE | PCSrcM;

  // The stall is raised in the first miss cycle, while still in RUN.
  // It is not delayed until the FSM has moved to MEM_WAIT.
  assign memStall = ((state == RUN) & MemReqM & ~MemReadyM) |
                    ((state == MEM_WAIT) & ~MemReadyM) |
                    (state == TRAP);

  always_comb begin
    nstate = state;
    case (state)
      RUN:      if (MemReqM && !MemReadyM) nstate = MEM_WAIT;
      MEM_WAIT: if (MemReadyM) nstate = RUN;
                else if (wait_cnt == WAIT_LAST) nstate = TRAP;
      TRAP:     nstate = TRAP;
      default:  nstate = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else begin
      state    <= nstate;
      wait_cnt <= (state == MEM_WAIT) ? wait_cnt + WW'(1) : '0;
      if (nstate == TRAP) MemTimeout <= 1'b1;
    end
  end

  // Outputs are gated by reset directly, so the pipeline sees bubbles
  // while reset is high, without waiting for a clock edge.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushW = 1'b0;
    if (reset) begin
      FlushD = 1'b1; FlushE = 1'b1; FlushW = 1'b1;
    end else begin
      // M has the younger result, so it wins when both M and W match.
      if (RegWriteM && RA1E == WA3M)      ForwardAE = 2'b10;
      else if (RegWriteW && RA1E == WA3W) ForwardAE = 2'b01;
      if (RegWriteM && RA2E == WA3M)      ForwardBE = 2'b10;
      else if (RegWriteW && RA2E == WA3W) ForwardBE = 2'b01;
      if (memStall) begin
        // A frozen pipeline must not drop D/E contents. W gets a bubble so
        // the stalled memory op is not written back more than once.
        StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = ldStall | pcPend;
        StallD = ldStall;
        FlushD = pcPend | PCSrcW | BranchTakenE; // flush beats stall in D
        FlushE = ldStall | BranchTakenE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (CntClr) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && StallCount != '1) StallCount <= StallCount + CNT_W'(1);
      if (FlushE && FlushCount != '1) FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM, CntClr;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [3:0] StallCount, FlushCount;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(4), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .CntClr(CntClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  typedef struct packed {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwe, rwm, rww, m2r, pcd, pce, pcm, pcw, bte;
    logic [1:0] fa, fb;
    logic [6:0] sf;   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM, CntClr} = '0;
  endtask

  task automatic apply(input vec_t v);
    RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
    WA3E = v.wa3e; WA3M = v.wa3m; WA3W = v.wa3w;
    RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww; MemtoRegE = v.m2r;
    PCSrcD = v.pcd; PCSrcE = v.pce; PCSrcM = v.pcm; PCSrcW = v.pcw;
    BranchTakenE = v.bte;
  endtask

  function automatic logic [10:0] outs();
    return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 13; i++) vt[i] = '0;
    vt[1].rwm = 1; vt[1].wa3m = 3; vt[1].ra1e = 3; vt[1].rww = 1; vt[1].wa3w = 3; vt[1].fa = 2'b10;
    vt[2].ra1e = 3; vt[2].rww = 1; vt[2].wa3w = 3; vt[2].wa3m = 3; vt[2].fa = 2'b01;
    vt[3].rwm = 1; vt[3].wa3m = 7; vt[3].ra1e = 7; vt[3].ra2e = 7; vt[3].fa = 2'b10; vt[3].fb = 2'b10;
    vt[4].rww = 1; vt[4].wa3w = 9; vt[4].ra2e = 9; vt[4].ra1e = 1; vt[4].fb = 2'b01;
    vt[5].m2r = 1; vt[5].rwe = 1; vt[5].wa3e = 5; vt[5].ra2d = 5; vt[5].ra1d = 1; vt[5].sf = 7'b1100010;
    vt[6].m2r = 1; vt[6].wa3e = 5; vt[6].ra2d = 5; vt[6].ra1d = 1;
    vt[7].m2r = 1; vt[7].rwe = 1; vt[7].wa3e = 6; vt[7].ra1d = 6; vt[7].ra2d = 2; vt[7].sf = 7'b1100010;
    vt[8].pcd = 1; vt[8].ra1d = 1; vt[8].sf = 7'b1000100;
    vt[9].pcw = 1; vt[9].ra1d = 1; vt[9].sf = 7'b0000100;
    vt[10].bte = 1; vt[10].ra1d = 1; vt[10].sf = 7'b0000110;
    vt[11].bte = 1; vt[11].m2r = 1; vt[11].rwe = 1; vt[11].wa3e = 4; vt[11].ra1d = 4; vt[11].sf = 7'b1100110;
    vt[12].pce = 1; vt[12].ra1d = 1; vt[12].sf = 7'b1000100;
    // vt[0]: nothing pending and no register matches.
    vt[0].ra1d = 1; vt[0].ra2d = 2; vt[0].ra1e = 3; vt[0].ra2e = 4;

    // Outputs while reset is held: drive inputs that would otherwise forward and stall.
    idle();
    apply(vt[11]); RegWriteM = 1; WA3M = 0; MemReqM = 1;
    #2;
    chk("reset_outs", outs(), {4'b0000, 7'b0000111});
    chk("reset_timeout", MemTimeout, 0);
    chk("reset_scnt", StallCount, 0);
    chk("reset_fcnt", FlushCount, 0);
    @(negedge clk);
    idle();
    reset = 1'b0;

    // Combinational table.
    for (int i = 0; i < 13; i++) begin
      apply(vt[i]);
      #2;
      chk($sformatf("vec%0d", i), outs(), {vt[i].fa, vt[i].fb, vt[i].sf});
      tick();
    end

    // Load-use bumps both counters by one.
    idle(); CntClr = 1; tick();
    CntClr = 0; apply(vt[5]); #2;
    chk("ld_use_outs", outs(), {4'b0, 7'b1100010});
    tick(); idle(); #2;
    chk("ld_use_scnt", StallCount, 1);
    chk("ld_use_fcnt", FlushCount, 1);
    // Branch together with a load-use stall.
    apply(vt[11]); #2;
    chk("br_ld_outs", outs(), {4'b0, 7'b1100110});
    tick(); idle(); #2;
    chk("br_ld_fcnt", FlushCount, 2);
    chk("br_ld_scnt", StallCount, 2);

    // Memory wait of 3 cycles overrides the load-use and branch requests.
    CntClr = 1; tick(); CntClr = 0;
    for (int c = 0; c < 3; c++) begin
      apply(vt[11]); MemReqM = 1; MemReadyM = 0; #2;
      chk($sformatf("memwait_c%0d", c), outs(), {4'b0, 7'b1111001});
      tick();
    end
    idle(); MemReqM = 1; MemReadyM = 1; #2;
    chk("memwait_done", outs(), 11'b0);
    tick(); idle(); #2;
    chk("memwait_scnt", StallCount, 3);
    chk("memwait_fcnt", FlushCount, 0);
    chk("memwait_run", outs(), 11'b0);

    // Timeout: one RUN miss cycle, then 4 MEM_WAIT cycles, then TRAP.
    CntClr = 1; tick(); CntClr = 0;
    MemReqM = 1; MemReadyM = 0;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk($sformatf("to_stall_c%0d", c), outs(), {4'b0, 7'b1111001});
      chk($sformatf("to_flag_c%0d", c), MemTimeout, 0);
      tick();
    end
    MemReqM = 0; MemReadyM = 1; #2;
    chk("trap_flag", MemTimeout, 1);
    chk("trap_stall", outs(), {4'b0, 7'b1111001});
    for (int c = 0; c < 20; c++) tick();
    #2;
    chk("trap_hold", outs(), {4'b0, 7'b1111001});
    chk("sat_scnt", StallCount, 15);
    chk("trap_fcnt", FlushCount, 0);

    // Asynchronous reset in the middle of a cycle.
    reset = 1'b1; #1;
    chk("async_flag", MemTimeout, 0);
    chk("async_scnt", StallCount, 0);
    @(negedge clk); reset = 1'b0; idle(); #2;
    chk("post_reset_run", outs(), 11'b0);

    // CntClr wins over increment while StallF is high.
    PCSrcD = 1; tick(); tick(); tick(); #2;
    chk("pc_scnt", StallCount, 3);
    CntClr = 1; tick(); #2;
    chk("clr_scnt", StallCount, 0);
    idle(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
